// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder_scan block: mode encodings and the one-cold helper.
package decoder_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Bits at or above 'width' are returned high so a caller may truncate freely.
    function automatic logic [31:0] onecold(input int unsigned idx, input int unsigned width);
        logic [31:0] valid;
        valid = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return ~(32'd1 << idx) | ~valid;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot prescaler for decoder_scan: counts 0..PRESCALE-1 while run is high, strobing on the last count.
module scan_prescaler #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic strobe
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] cnt;

    // With PRESCALE=1 the counter sits at 0 == LAST, so strobe follows run every cycle.
    assign strobe = run && (cnt == LAST);

    // NOTE: sequential state is assigned only with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + PS_W'(1);
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-cold decoder with manual and self-scanning modes.
// Optional macro DECODER_SCAN_BLANK_EN inserts one all-high cycle on every scan advance.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W    = 2,
    parameter int PRESCALE = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      addr,
    input  logic                  hold,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      idx,
    output logic                  tick,
    output logic                  wrap
);

    localparam int NOUT = 2**SEL_W;

    logic             run;
    logic             clr;
    logic             strobe;
    logic [SEL_W-1:0] idx_inc;
    logic [NOUT-1:0]  oc_addr;
    logic [NOUT-1:0]  oc_idx;
    logic [NOUT-1:0]  oc_inc;

    assign run = en && (mode == MODE_SCAN) && !hold;
    assign clr = en && (mode == MODE_MANUAL);

    scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .clr    (clr),
        .strobe (strobe)
    );

    // NOTE: every always_comb output is fully assigned on every pass, so no latch can be inferred.
    always_comb begin
        idx_inc = idx + SEL_W'(1);
        oc_addr = NOUT'(onecold(32'(addr), NOUT));
        oc_idx  = NOUT'(onecold(32'(idx), NOUT));
        oc_inc  = NOUT'(onecold(32'(idx_inc), NOUT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            y    <= '1;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (!en) begin
            y    <= '1;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (mode == MODE_MANUAL) begin
            idx  <= addr;
            y    <= oc_addr;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (hold) begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (strobe) begin
            idx  <= idx_inc;
            tick <= 1'b1;
            wrap <= (idx == '1);
`ifdef DECODER_SCAN_BLANK_EN
            // Dead cycle before the new select; the next edge restores oc_idx.
            y    <= '1;
`else
            y    <= oc_inc;
`endif
        end else begin
            y    <= oc_idx;
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Registered, parametrised N-to-2^N decoder with active-low (one-cold) outputs, enable, and two modes. In manual mode it decodes an address input. In scan mode it steps through all outputs automatically at a prescaled rate. It drives multiplexed display digit selects and bank/chip selects, and replaces the fixed 2-to-4 combinational decoder wherever a clocked or self-scanning select is needed.

## Interface
Parameters:
- SEL_W, default 2: select index width; the decoder drives 2**SEL_W outputs. Legal range 1..5.
- PRESCALE, default 50000: clock cycles per scan slot. Must be >= 1; PS_W = $clog2(PRESCALE), with a minimum of 1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- en  in  1: enable. 0 forces all outputs high and freezes state.
- mode  in  1: 0 = manual (decode addr), 1 = scan.
- addr  in  SEL_W: manual-mode index.
- hold  in  1: in scan mode, freezes the prescaler and idx. Ignored in manual mode.
- y  out  2**SEL_W: active-low one-cold select, registered.
- idx  out  SEL_W: index currently selected, registered.
- tick  out  1: one-cycle pulse in the cycle idx shows a scan-advanced value.
- wrap  out  1: one-cycle pulse coincident with tick when idx wraps from 2**SEL_W-1 to 0.

## Operation
- Reset values: idx=0, prescaler=0, y all ones, tick=0, wrap=0. Reset has priority over every other input.
- Priority below reset: en, then mode, then hold.
- en=0:
  - y <= all ones.
  - idx and prescaler hold their values.
  - tick and wrap are 0.
- en=1, mode=0 (manual):
  - idx <= addr.
  - prescaler <= 0.
  - y <= ~(1 << addr).
  - tick and wrap are 0.
- en=1, mode=1, hold=1: all state holds, y keeps its current value, tick and wrap are 0.
- en=1, mode=1, hold=0:
  - Prescaler counts 0..PRESCALE-1.
  - At PRESCALE-1 the prescaler returns to 0, idx <= idx+1 modulo 2**SEL_W, and tick <= 1. wrap <= 1 if the old idx was all ones.
  - Otherwise the prescaler increments, idx holds, and tick and wrap are 0.
  - y <= ~(1 << next idx).
- PRESCALE=1: idx advances every enabled cycle and tick stays high continuously.
- y is always exactly one-cold, or all ones. No other pattern is legal.
- Switching mode 1->0: idx takes addr on the next edge, and the prescaler clears.
- Switching mode 0->1: scanning starts from the current idx. The first advance comes PRESCALE enabled, non-held cycles later.
- en returning to 1 in scan mode: counting resumes from the frozen prescaler value, and y is restored on the first enabled edge.

## Timing
- Manual mode: addr change at edge k is visible on idx and y after edge k+1 (1-cycle latency).
- Scan mode: idx, y, tick and wrap all update on the same edge. There is no combinational path from any input to any output.
- en falling: y goes all ones after the next edge (1 cycle).
- Reset asserted mid-scan: outputs take their reset values after the next edge. The slot count restarts from idx=0 and prescaler=0.

## Configuration
- DECODER_SCAN_BLANK_EN defined: on each scan advance, y is all ones for exactly one cycle (the tick cycle). The new one-cold value appears on the following edge. This is anti-ghosting dead time. idx, tick and wrap timing are unchanged. Manual mode is unaffected.
- Not defined: y switches directly to the new select on the tick edge, with no blank cycle.

## Structure
- Shared package decoder_pkg holds:
  - localparams MODE_MANUAL=1'b0 and MODE_SCAN=1'b1;
  - function onecold(idx, width), which returns ~(1 << idx).
- Sub-module scan_prescaler(clk, rst, run, clr, strobe), parametrised by PRESCALE, provides the prescaler counter and strobe. decoder_scan instantiates it once and holds the idx register and output logic itself.

## Test plan
- Reset, then en=1, mode=0, addr=2 (SEL_W=2): y=4'b1011 and idx=2 one cycle later; tick stays 0.
- SEL_W=2, PRESCALE=4, mode=1: idx steps 0,1,2,3,0 every 4 cycles; y=1110,1101,1011,0111,1110; wrap pulses only on 3->0.
- Scan with hold=1 for 10 cycles mid-slot: idx, y and prescaler are frozen; on release, the slot finishes its remaining counts.
- en=0 during scan: y=4'b1111 after one edge and idx is unchanged; re-enable restores y=~(1<<idx) after one edge.
- rst pulse mid-scan at idx=3: next edge gives idx=0, y=1111, tick=0; the first advance comes PRESCALE cycles after rst deasserts.
- With DECODER_SCAN_BLANK_EN, PRESCALE=2: each advance shows y=1111 for one cycle, then the new one-cold value; without the macro there is no blank cycle.
